// File: rtl/bus_arbiter_if.sv
// Arbiter-side bundle: per-master request/hold in, registered grant status out.
// The master modport is the cache-controller view; slave is the arbiter view.
interface bus_arbiter_if #(
    parameter int N = 4
);
    localparam int OW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  breq;
    logic [N-1:0]  bhold;
    logic [N-1:0]  bgnt;
    logic [OW-1:0] owner;
    logic          busy;
    logic          hold_timeout;

    modport master (
        output breq, bhold,
        input  bgnt, owner, busy, hold_timeout
    );

    modport slave (
        input  breq, bhold,
        output bgnt, owner, busy, hold_timeout
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin split-transaction bus arbiter with one-cycle grant latency,
// bhold-extended tenures and a hold-limit forced revocation.
//   state   | meaning
//   IDLE    | no master granted, bgnt all-zero
//   GRANTED | exactly one bgnt bit set, owner drives the bus
module bus_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic          clock,
    input  logic          reset,
    bus_arbiter_if.slave  bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, GRANTED} state_t;

    state_t        r_state,      w_state_nxt;
    logic [N-1:0]  r_bgnt,       w_bgnt_nxt;
    logic [PW-1:0] r_owner,      w_owner_nxt;
    logic [PW-1:0] r_ptr,        w_ptr_nxt;
    logic [CW-1:0] r_hold_cnt,   w_hold_cnt_nxt;
    logic          r_busy;
    logic          r_hold_timeout, w_hold_timeout_nxt;

    logic          w_arb;
    logic [N-1:0]  w_req;
    logic [PW-1:0] w_start;
    logic          w_found;
    logic [PW-1:0] w_win;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_bgnt         <= '0;
            r_owner        <= '0;
            r_ptr          <= '0;
            r_hold_cnt     <= '0;
            r_busy         <= 1'b0;
            r_hold_timeout <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_bgnt         <= w_bgnt_nxt;
            r_owner        <= w_owner_nxt;
            r_ptr          <= w_ptr_nxt;
            r_hold_cnt     <= w_hold_cnt_nxt;
            r_busy         <= |w_bgnt_nxt;
            r_hold_timeout <= w_hold_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_bgnt_nxt         = r_bgnt;
        w_owner_nxt        = r_owner;
        w_ptr_nxt          = r_ptr;
        w_hold_cnt_nxt     = r_hold_cnt;
        w_hold_timeout_nxt = 1'b0;
        w_arb              = 1'b0;
        w_req              = bus.breq;
        w_start            = r_ptr;
        w_found            = 1'b0;
        w_win              = '0;

        case (r_state)
            IDLE: begin
                w_hold_cnt_nxt = '0;
                w_arb          = |bus.breq;
            end
            GRANTED: begin
                if (bus.bhold[r_owner] && (r_hold_cnt < CW'(MAX_HOLD))) begin
                    w_hold_cnt_nxt = r_hold_cnt + 1'b1;
                end else begin
                    // Tenure over: the old owner sits out this one decision.
                    w_arb              = 1'b1;
                    w_req[r_owner]     = 1'b0;
                    w_start            = (r_owner == PW'(N - 1)) ? '0 : r_owner + 1'b1;
                    w_ptr_nxt          = w_start;
                    w_hold_timeout_nxt = bus.bhold[r_owner];
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        for (int i = 0; i < N; i++) begin
            if (!w_found && w_req[(int'(w_start) + i) % N]) begin
                w_found = 1'b1;
                w_win   = PW'((int'(w_start) + i) % N);
            end
        end

        if (w_arb) begin
            w_hold_cnt_nxt = '0;
            if (w_found) begin
                w_state_nxt = GRANTED;
                w_bgnt_nxt  = N'(1) << w_win;
                w_owner_nxt = w_win;
            end else begin
                w_state_nxt = IDLE;
                w_bgnt_nxt  = '0;
                w_owner_nxt = '0;
            end
        end
    end

    assign bus.bgnt         = r_bgnt;
    assign bus.owner        = r_owner;
    assign bus.busy         = r_busy;
    assign bus.hold_timeout = r_hold_timeout;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed cycle-by-cycle vectors for bus_arbiter (N=4, MAX_HOLD=4) plus
// hand-written reset sequences; inputs change on negedge, outputs sampled 1ns after posedge.
module tb_bus_arbiter;
    logic clock;
    logic reset;

    bus_arbiter_if #(.N(4)) bus ();

    bus_arbiter #(.N(4), .MAX_HOLD(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] breq;
        logic [3:0] bhold;
        logic [3:0] bgnt;
        logic [1:0] owner;
        logic       busy;
        logic       to;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    vec_t vecs[25];

    function automatic vec_t mk(logic [3:0] rq, logic [3:0] hd, logic [3:0] gn,
                                logic [1:0] ow, logic bs, logic t);
        vec_t v;
        v.breq = rq; v.bhold = hd; v.bgnt = gn; v.owner = ow; v.busy = bs; v.to = t;
        return v;
    endfunction

    task automatic check(input string name, input logic [3:0] gn, input logic [1:0] ow,
                         input logic bs, input logic t);
        n_vec++;
        if (bus.bgnt !== gn || bus.owner !== ow || bus.busy !== bs || bus.hold_timeout !== t) begin
            n_err++;
            $display("FAIL %s: got bgnt=%b owner=%0d busy=%b hold_timeout=%b, want bgnt=%b owner=%0d busy=%b hold_timeout=%b",
                     name, bus.bgnt, bus.owner, bus.busy, bus.hold_timeout, gn, ow, bs, t);
        end
    endtask

    always @(negedge clock) begin
        if (!$onehot0(bus.bgnt)) begin
            n_err++;
            $display("FAIL onehot0: got bgnt=%b, want at most one bit set", bus.bgnt);
        end
    end

    initial begin
        // Reset release and round robin over all four masters
        vecs[0]  = mk(4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);
        vecs[1]  = mk(4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0);
        vecs[2]  = mk(4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);
        vecs[3]  = mk(4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0);
        vecs[4]  = mk(4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);
        vecs[5]  = mk(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        // Single requester 2, then ptr=3 shows up as master 3 winning 1111
        vecs[6]  = mk(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);
        vecs[7]  = mk(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        vecs[8]  = mk(4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0);
        vecs[9]  = mk(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        // Master 1 holds for three cycles while master 3 waits
        vecs[10] = mk(4'b1010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0);
        vecs[11] = mk(4'b1010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
        vecs[12] = mk(4'b1010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
        vecs[13] = mk(4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0);
        // Lone re-requesting owner must sit out one cycle
        vecs[14] = mk(4'b1000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        vecs[15] = mk(4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0);
        vecs[16] = mk(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        // Master 0 holds forever: 5 grant cycles then forced handoff to 2
        vecs[17] = mk(4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);
        vecs[18] = mk(4'b0101, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
        vecs[19] = mk(4'b0101, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
        vecs[20] = mk(4'b0101, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
        vecs[21] = mk(4'b0101, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
        vecs[22] = mk(4'b0101, 4'b0001, 4'b0100, 2'd2, 1'b1, 1'b1);
        // Non-owner bhold ignored; timeout pulse lasts one cycle
        vecs[23] = mk(4'b0101, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
        vecs[24] = mk(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

        reset     = 1'b0;
        bus.breq  = 4'b1111;
        bus.bhold = 4'b0000;
        repeat (3) @(posedge clock);
        #1;
        check("in_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        reset = 1'b1;

        for (int i = 0; i < 25; i++) begin
            @(negedge clock);
            bus.breq  = vecs[i].breq;
            bus.bhold = vecs[i].bhold;
            @(posedge clock);
            #1;
            check($sformatf("vec%0d", i), vecs[i].bgnt, vecs[i].owner, vecs[i].busy, vecs[i].to);
        end

        // ptr is now 1; master 3 wins, holds, and is killed by reset mid-cycle
        @(negedge clock);
        bus.breq  = 4'b1000;
        bus.bhold = 4'b0000;
        @(posedge clock);
        #1;
        check("rst_pre_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
        @(negedge clock);
        bus.bhold = 4'b1000;
        @(posedge clock);
        #1;
        check("rst_pre_hold", 4'b1000, 2'd3, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("rst_async", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clock);
        bus.breq  = 4'b1001;
        bus.bhold = 4'b0000;
        @(posedge clock);
        #1;
        check("rst_held", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("rst_ptr_zero", 4'b0001, 2'd0, 1'b1, 1'b0);

        @(negedge clock);
        bus.breq = 4'b0000;
        @(posedge clock);
        #1;
        check("final_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
